// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: plays a small stored program of {mode, A, B} words into
// an accumulator ALU. Each instruction takes one ISSUE cycle and one CAPTURE
// cycle. The sequencer returns each accumulator result with a valid strobe
// and keeps a sticky record of the first nonzero ALU error code.
// Optional feature macro: ALU_SEQ_HALT_ON_ERROR_EN. When it is defined, the
// run ends after the capture of the first instruction that reports an error.
module alu_op_sequencer #(
    parameter int datalen  = 8,
    parameter int modelen  = 4,
    parameter int errorlen = 2,
    parameter int addrlen  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [addrlen-1:0]            prog_addr,
    input  logic [modelen+2*datalen-1:0]  prog_data,
    input  logic [addrlen:0]              prog_len,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [datalen-1:0]            alu_inA,
    output logic [datalen-1:0]            alu_inB,
    output logic [modelen-1:0]            alu_mode,
    output logic                          alu_clear,
    input  logic [datalen-1:0]            alu_out,
    input  logic [errorlen-1:0]           alu_err,
    output logic [datalen-1:0]            result,
    output logic                          result_valid,
    output logic [errorlen-1:0]           err_code,
    output logic [addrlen-1:0]            err_pc
);

    localparam int wordlen = modelen + 2 * datalen;
    localparam int depth   = 1 << addrlen;
    localparam logic [addrlen:0] depth_c = (addrlen + 1)'(depth);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_r;
    logic [addrlen-1:0]   pc_r;
    logic [addrlen:0]     len_r;
    logic [wordlen-1:0]   store_r [depth];
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
    logic                 err_hit_r;
`endif

    logic [addrlen:0]     len_sat_s;
    logic [addrlen:0]     pc_inc_s;
    logic [wordlen-1:0]   issue_word_s;
    logic [wordlen-1:0]   next_word_s;
    logic                 err_now_s;
    logic                 halt_s;

    // Program store: host writes land only while no run is in progress.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            store_r[prog_addr] <= prog_data;
        end else begin
            store_r[prog_addr] <= store_r[prog_addr];
        end
    end

    // Length saturation, next-pc arithmetic, store lookups and run-end decision.
    always_comb begin
        len_sat_s    = (prog_len > depth_c) ? depth_c : prog_len;
        pc_inc_s     = {1'b0, pc_r} + {{addrlen{1'b0}}, 1'b1};
        issue_word_s = store_r[pc_r];
        next_word_s  = store_r[pc_inc_s[addrlen-1:0]];
        err_now_s    = (alu_err != {errorlen{1'b0}});
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
        halt_s       = (pc_inc_s == len_r) || err_hit_r;
`else
        halt_s       = (pc_inc_s == len_r);
`endif
    end

    // Sequencer FSM: every output is registered on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= {addrlen{1'b0}};
            len_r        <= {(addrlen + 1){1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            alu_inA      <= {datalen{1'b0}};
            alu_inB      <= {datalen{1'b0}};
            alu_mode     <= {modelen{1'b0}};
            alu_clear    <= 1'b0;
            result       <= {datalen{1'b0}};
            result_valid <= 1'b0;
            err_code     <= {errorlen{1'b0}};
            err_pc       <= {addrlen{1'b0}};
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
            err_hit_r    <= 1'b0;
`endif
        end else begin
            done         <= 1'b0;
            result_valid <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        len_r     <= len_sat_s;
                        pc_r      <= {addrlen{1'b0}};
                        err_code  <= {errorlen{1'b0}};
                        err_pc    <= {addrlen{1'b0}};
                        busy      <= 1'b1;
                        alu_clear <= 1'b1;
                        state_r   <= CLEAR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CLEAR: begin
                    alu_clear <= 1'b0;
                    if (len_r == {(addrlen + 1){1'b0}}) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        alu_mode <= issue_word_s[wordlen-1 -: modelen];
                        alu_inA  <= issue_word_s[2*datalen-1 -: datalen];
                        alu_inB  <= issue_word_s[datalen-1:0];
                        state_r  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (err_now_s && (err_code == {errorlen{1'b0}})) begin
                        err_code <= alu_err;
                        err_pc   <= pc_r;
                    end else begin
                        err_code <= err_code;
                    end
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
                    err_hit_r <= err_now_s;
`endif
                    alu_mode <= {modelen{1'b0}};
                    alu_inA  <= {datalen{1'b0}};
                    alu_inB  <= {datalen{1'b0}};
                    state_r  <= CAPTURE;
                end
                CAPTURE: begin
                    result       <= alu_out;
                    result_valid <= 1'b1;
                    pc_r         <= pc_inc_s[addrlen-1:0];
                    if (halt_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        alu_mode <= next_word_s[wordlen-1 -: modelen];
                        alu_inA  <= next_word_s[2*datalen-1 -: datalen];
                        alu_inB  <= next_word_s[datalen-1:0];
                        state_r  <= ISSUE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    alu_clear <= 1'b0;
                    alu_mode  <= {modelen{1'b0}};
                    alu_inA   <= {datalen{1'b0}};
                    alu_inB   <= {datalen{1'b0}};
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. It contains a small accumulator ALU and a
// program-level reference model that predicts results, error record and cycle timing.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        busy, done, alu_clear, result_valid;
    logic [7:0]  alu_inA, alu_inB, alu_out, result;
    logic [3:0]  alu_mode, err_pc;
    logic [1:0]  alu_err, err_code;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start),
        .busy(busy), .done(done), .alu_inA(alu_inA), .alu_inB(alu_inB),
        .alu_mode(alu_mode), .alu_clear(alu_clear), .alu_out(alu_out),
        .alu_err(alu_err), .result(result), .result_valid(result_valid),
        .err_code(err_code), .err_pc(err_pc)
    );

    // Accumulator ALU behaviour: returns {err, new_acc}.
    function automatic logic [9:0] alu_fn(input logic [3:0] m, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] acc);
        logic [8:0] s;
        logic [7:0] r;
        logic [1:0] e;
        e = 2'b00;
        r = acc;
        case (m)
            4'd1: r = ~acc;
            4'd2: r = {acc[6:0], 1'b0};
            4'd3: r = {1'b0, acc[7:1]};
            4'd4: r = a;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; e = s[8] ? 2'b01 : 2'b00; end
            4'd9: begin r = a - b; e = (a < b) ? 2'b10 : 2'b00; end
            default: r = acc;
        endcase
        return {e, r};
    endfunction

    logic [7:0] acc;
    logic [9:0] alu_next;
    assign alu_next = alu_fn(alu_mode, alu_inA, alu_inB, acc);
    assign alu_err  = alu_next[9:8];
    assign alu_out  = acc;
    always @(posedge clk) begin
        if (reset || alu_clear) acc <= 8'h00;
        else acc <= alu_next[7:0];
    end

    // Bench copy of program store and reference-model results.
    logic [19:0] prog_m [16];
    logic [7:0]  exp_q [$];
    logic [1:0]  exp_err;
    int          exp_pc;
    int          n_exec;
    logic [7:0]  res_hold;
    int          checks = 0;
    int          passes = 0;
    int          busy_cnt, rv_cnt, first_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Program-level model: run the instruction list through the ALU behaviour.
    task automatic model_run(input int len_in);
        int n;
        logic [7:0] a;
        logic [9:0] r;
        n = (len_in > 16) ? 16 : len_in;
        a = 8'h00;
        exp_q.delete();
        exp_err = 2'b00;
        exp_pc  = 0;
        n_exec  = 0;
        for (int i = 0; i < n; i++) begin
            r = alu_fn(prog_m[i][19:16], prog_m[i][15:8], prog_m[i][7:0], a);
            a = r[7:0];
            exp_q.push_back(a);
            n_exec++;
            if (r[9:8] != 2'b00 && exp_err == 2'b00) begin
                exp_err = r[9:8];
                exp_pc  = i;
            end
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
            if (r[9:8] != 2'b00) break;
`endif
        end
    endtask

    task automatic wr_prog(input int addr, input logic [19:0] data);
        prog_we = 1'b1; prog_addr = addr[3:0]; prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
        prog_m[addr] = data;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_clear"}, alu_clear, 0);
        chk({tag, "_mode"}, alu_mode, 0);
        chk({tag, "_ab"}, {alu_inA, alu_inB}, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_err"}, {err_code, err_pc}, 0);
    endtask

    // One run: start, then per-cycle compare against the model's timeline.
    // abort_k>0 asserts reset in cycle abort_k; inj_k>0 injects start+write in that cycle.
    task automatic do_run(input int len_in, input int abort_k, input int inj_k,
                          input logic ws, input logic [19:0] ws_data);
        int last, n, ii, ri;
        if (ws) prog_m[0] = ws_data;
        model_run(len_in);
        n = n_exec;
        last = (abort_k > 0) ? abort_k + 1 : 2 * n + 3;
        busy_cnt = 0; rv_cnt = 0; first_rv = 0;
        start = 1'b1; prog_len = len_in[4:0];
        prog_we = ws; prog_addr = 4'd0; prog_data = ws_data;
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (abort_k > 0 && k == abort_k + 1) begin
                res_hold = 8'h00;
                chk_idle_zero("abort");
            end else begin
                ii = (k >= 2 && k <= 2 * n && (k % 2) == 0) ? (k - 2) / 2 : -1;
                ri = (k >= 4 && (k % 2) == 0 && (k - 4) / 2 < n) ? (k - 4) / 2 : -1;
                if (ri >= 0) res_hold = exp_q[ri];
                chk("busy", busy, (k <= 1 + 2 * n) ? 1 : 0);
                chk("done", done, (k == 2 + 2 * n) ? 1 : 0);
                chk("result_valid", result_valid, (ri >= 0) ? 1 : 0);
                chk("result", result, res_hold);
                chk("alu_clear", alu_clear, (k == 1) ? 1 : 0);
                chk("alu_mode", alu_mode, (ii >= 0) ? prog_m[ii][19:16] : 4'h0);
                chk("alu_inA", alu_inA, (ii >= 0) ? prog_m[ii][15:8] : 8'h00);
                chk("alu_inB", alu_inB, (ii >= 0) ? prog_m[ii][7:0] : 8'h00);
                if (k == 2 + 2 * n) begin
                    chk("err_code", err_code, exp_err);
                    chk("err_pc", err_pc, exp_pc);
                end
                busy_cnt += busy;
                if (result_valid) begin
                    rv_cnt++;
                    if (first_rv == 0) first_rv = k;
                end
            end
            if (k == inj_k) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 20'hFFFFF;
            end
            if (k == abort_k) reset = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; prog_we = 1'b0; reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; prog_we = 1'b0; prog_addr = 4'd0;
        prog_data = 20'd0; prog_len = 5'd4; res_hold = 8'h00;
        for (int i = 0; i < 16; i++) prog_m[i] = 20'd0;
        // Reset for two cycles with start held high.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_idle_zero("reset");
        end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 16; i++) wr_prog(i, 20'd0);

        // Directed program: Load 0x51, OR 0x55|0x58, ShiftLeft, ShiftRight.
        wr_prog(0, {4'd4, 8'h51, 8'h00});
        wr_prog(1, {4'd6, 8'h55, 8'h58});
        wr_prog(2, {4'd2, 8'h00, 8'h00});
        wr_prog(3, {4'd3, 8'h00, 8'h00});
        do_run(4, 0, 0, 1'b0, 20'd0);
        chk("model_r0", exp_q[0], 8'h51);
        chk("model_r1", exp_q[1], 8'h5D);
        chk("model_r2", exp_q[2], 8'hBA);
        chk("model_r3", exp_q[3], 8'h5D);
        chk("busy_cycles", busy_cnt, 9);
        chk("first_rv_cycle", first_rv, 4);
        chk("rv_count", rv_cnt, 4);

        // Empty program.
        do_run(0, 0, 0, 1'b0, 20'd0);
        chk("len0_busy_cycles", busy_cnt, 1);
        chk("len0_rv_count", rv_cnt, 0);

        // Start and write injected during ISSUE of pc=1, then rerun with retained store.
        do_run(4, 0, 4, 1'b0, 20'd0);
        do_run(4, 0, 0, 1'b0, 20'd0);
        chk("store_kept", exp_q[0], 8'h51);
        chk("store_kept_rv", rv_cnt, 4);

        // Reset during CAPTURE of pc=2 (cycle 7), then fresh run.
        do_run(4, 7, 0, 1'b0, 20'd0);
        do_run(4, 0, 0, 1'b0, 20'd0);
        chk("rerun_rv", rv_cnt, 4);

        // Overflow error on pc=1 of a three-instruction program.
        wr_prog(0, {4'd4, 8'hF0, 8'h00});
        wr_prog(1, {4'd8, 8'hC0, 8'h80});
        wr_prog(2, {4'd7, 8'h0F, 8'hFF});
        do_run(3, 0, 0, 1'b0, 20'd0);
        chk("model_err", exp_err, 2'b01);
        chk("model_err_pc", exp_pc, 1);
        chk("dut_err_code", err_code, 2'b01);
        chk("dut_err_pc", err_pc, 1);
`ifdef ALU_SEQ_HALT_ON_ERROR_EN
        chk("err_rv_count", rv_cnt, 2);
`else
        chk("err_rv_count", rv_cnt, 3);
`endif

        // Randomized programs, including saturating lengths and write-with-start.
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < 16; i++)
                wr_prog(i, {4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom)});
            do_run(int'($urandom_range(0, 20)), 0, 0, (r % 4) == 0,
                   {4'($urandom_range(0, 9)), 8'($urandom), 8'($urandom)});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
